// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the shared data-memory/IO bus: port 0 is the CPU, port 1 the debug loader.
// Contention is fixed-priority to port 0 unless DMEM_ARB_RR_EN is defined (round-robin).
module dmem_arbiter #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] draddr,
  output logic          dwrite,
  output logic          dread,
  output logic [DW-1:0] dwdata,
  input  logic [DW-1:0] drdata,
  output logic [15:0]   txn_count,
  output logic          owner
);

  typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic          winner;

`ifdef DMEM_ARB_RR_EN
  logic last_q;

  // Under contention the port not served last wins; a lone request always wins.
  always_comb begin
    if (req0 && req1) begin
      winner = ~last_q;
    end else begin
      winner = req1;
    end
  end
`else
  always_comb begin
    winner = ~req0;
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StIdle;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      owner     <= 1'b0;
      txn_count <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
`ifdef DMEM_ARB_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req0 || req1) begin
            owner   <= winner;
            addr_q  <= winner ? addr1 : addr0;
            we_q    <= winner ? we1 : we0;
            wdata_q <= winner ? wdata1 : wdata0;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (owner) begin
            ack1 <= 1'b1;
            if (!we_q) rdata1 <= drdata;
          end else begin
            ack0 <= 1'b1;
            if (!we_q) rdata0 <= drdata;
          end
          txn_count <= txn_count + 16'd1;
`ifdef DMEM_ARB_RR_EN
          last_q    <= owner;
`endif
          state_q   <= StAck;
        end
        StAck: begin
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Strobes are gated with reset so nothing commits on a reset edge, even from access.
  assign draddr = addr_q;
  assign dwdata = wdata_q;
  assign dwrite = reset && (state_q == StAccess) && we_q;
  assign dread  = reset && (state_q == StAccess) && !we_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-timeline reference model plus directed pins.
module tb_dmem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam logic [15:0] IoAddr = 16'hFF00;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        r_req   [2];
  logic        r_we    [2];
  logic [15:0] r_addr  [2];
  logic [15:0] r_wdata [2];
  logic        ack0, ack1, dwrite, dread, owner;
  logic [15:0] rdata0, rdata1, draddr, dwdata, drdata, txn_count;
  logic [15:0] io_sw;
  logic        mem_init;
  logic [15:0] mem [0:255];

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .req0(r_req[0]), .we0(r_we[0]), .addr0(r_addr[0]), .wdata0(r_wdata[0]),
    .ack0(ack0), .rdata0(rdata0),
    .req1(r_req[1]), .we1(r_we[1]), .addr1(r_addr[1]), .wdata1(r_wdata[1]),
    .ack1(ack1), .rdata1(rdata1),
    .draddr(draddr), .dwrite(dwrite), .dread(dread), .dwdata(dwdata), .drdata(drdata),
    .txn_count(txn_count), .owner(owner)
  );

  // Bus environment: RAM below 256, a switch register at IoAddr.
  assign drdata = (draddr == IoAddr) ? io_sw : mem[draddr[7:0]];
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(i * 3);
    end else if (dwrite && draddr != IoAddr) begin
      mem[draddr[7:0]] <= dwdata;
    end
  end

  // Reference model: state of the bus as seen from the transaction timeline.
  logic [15:0] ref_mem [0:255];
  int          cyc, checks, errors;
  bit          m_busy, m_port, m_we;
  int          m_idle_from;
  logic [15:0] m_addr, m_wdata;
`ifdef DMEM_ARB_RR_EN
  bit          m_last;
`endif
  bit          e_ack [2];
  logic [15:0] e_rdata [2];
  bit          e_owner, e_dwrite, e_dread;
  logic [15:0] e_count, e_draddr, e_dwdata;

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return (a == IoAddr) ? io_sw : ref_mem[a[7:0]];
  endfunction

  // Outputs expected after the coming edge, given the inputs now on the pins.
  task automatic predict();
    int e;
    e = cyc + 1;
    e_ack[0] = 1'b0;
    e_ack[1] = 1'b0;
    if (!reset) begin
      m_busy = 1'b0; m_we = 1'b0; m_idle_from = e + 1;
`ifdef DMEM_ARB_RR_EN
      m_last = 1'b1;
`endif
      e_rdata[0] = '0; e_rdata[1] = '0; e_owner = 1'b0; e_count = '0;
      e_draddr = '0; e_dwdata = '0;
    end else if (m_busy) begin
      if (m_we) begin
        if (m_addr != IoAddr) ref_mem[m_addr[7:0]] = m_wdata;
      end else begin
        e_rdata[m_port] = ref_read(m_addr);
      end
      e_ack[m_port] = 1'b1;
      e_count = e_count + 16'd1;
`ifdef DMEM_ARB_RR_EN
      m_last = m_port;
`endif
      m_busy = 1'b0;
      m_idle_from = e + 2;
    end else if (e >= m_idle_from && (r_req[0] || r_req[1])) begin
      bit p;
`ifdef DMEM_ARB_RR_EN
      if (r_req[0] && r_req[1]) p = !m_last;
      else p = r_req[1];
`else
      if (r_req[0] && r_req[1]) p = 1'b0;
      else p = r_req[1];
`endif
      m_busy = 1'b1; m_port = p; m_we = r_we[p]; m_addr = r_addr[p]; m_wdata = r_wdata[p];
      e_owner = p; e_draddr = m_addr; e_dwdata = m_wdata;
    end
    e_dwrite = m_busy && m_we;
    e_dread  = m_busy && !m_we;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    check("ack0", 16'(ack0), 16'(e_ack[0]));
    check("ack1", 16'(ack1), 16'(e_ack[1]));
    check("rdata0", rdata0, e_rdata[0]);
    check("rdata1", rdata1, e_rdata[1]);
    check("owner", 16'(owner), 16'(e_owner));
    check("txn_count", txn_count, e_count);
    check("dwrite", 16'(dwrite), 16'(e_dwrite));
    check("dread", 16'(dread), 16'(e_dread));
    check("draddr", draddr, e_draddr);
    check("dwdata", dwdata, e_dwdata);
  endtask

  // Called at a negedge with inputs set; returns at the next negedge after checking.
  task automatic cycle();
    predict();
    @(negedge clock);
    cyc++;
    compare_all();
  endtask

  task automatic do_txn(input int p, input bit we, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output int ndw);
    bit done;
    r_req[p] = 1'b1; r_we[p] = we; r_addr[p] = a; r_wdata[p] = d;
    lat = 0; ndw = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      lat++;
      if (dwrite) ndw++;
      done = e_ack[p];
    end
    check("txn_done", 16'(done), 16'd1);
    r_req[p] = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int lat, ndw, a0, a1, first;
    bit seen;
    checks = 0; errors = 0; cyc = 0; io_sw = 16'h0001; mem_init = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i * 3);
    reset = 1'b0;
    r_req[0] = 1'b1; r_we[0] = 1'b1; r_addr[0] = 16'h0004; r_wdata[0] = 16'h00A5;
    r_req[1] = 1'b0; r_we[1] = 1'b0; r_addr[1] = 16'h0000; r_wdata[1] = 16'h0000;

    // Reset held two cycles with a write pending.
    #1 check("rst_dwrite_pre", 16'(dwrite), 16'd0);
    cycle();
    mem_init = 1'b0;
    cycle();
    check("rst_count", txn_count, 16'h0000);
    check("rst_ack0", 16'(ack0), 16'd0);
    reset = 1'b1;
    r_req[0] = 1'b0;
    cycle();
    check("rst_idle_dwrite", 16'(dwrite), 16'd0);

    // Single write then read on port 0.
    do_txn(0, 1'b1, 16'h0004, 16'h00A5, lat, ndw);
    check("wr_latency", 16'(lat), 16'd2);
    check("wr_dwrite_cycles", 16'(ndw), 16'd1);
    do_txn(0, 1'b0, 16'h0004, 16'h0000, lat, ndw);
    check("rd_rdata0", rdata0, 16'h00A5);
    check("rd_count", txn_count, 16'd2);
    check("rd_no_dwrite", 16'(ndw), 16'd0);

    // Contention from reset: both ports read continuously for 12 cycles.
    apply_reset();
    r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 16'h0004;
    r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = 16'h0005;
    a0 = 0; a1 = 0; first = -1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (ack0) begin a0++; if (first < 0) first = 0; end
      if (ack1) begin a1++; if (first < 0) first = 1; end
    end
    r_req[0] = 1'b0; r_req[1] = 1'b0;
    check("cont_first", 16'(first), 16'd0);
`ifdef DMEM_ARB_RR_EN
    check("cont_ack0", 16'(a0), 16'd2);
    check("cont_ack1", 16'(a1), 16'd2);
    check("cont_rdata1", rdata1, 16'h000F);
`else
    check("cont_ack0", 16'(a0), 16'd4);
    check("cont_ack1", 16'(a1), 16'd0);
    check("cont_rdata1", rdata1, 16'h0000);
`endif

    // Port 1 reads the IO switch register.
    io_sw = 16'h0001;
    do_txn(1, 1'b0, IoAddr, 16'h0000, lat, ndw);
    check("io_rdata1", rdata1, 16'h0001);
    check("io_rdata0_kept", rdata0, 16'h00A5);
    check("io_owner", 16'(owner), 16'd1);

    // Reset during the access cycle of a write must not commit it.
    do_txn(0, 1'b1, 16'h0008, 16'h1111, lat, ndw);
    r_req[0] = 1'b1; r_we[0] = 1'b1; r_addr[0] = 16'h0008; r_wdata[0] = 16'h2222;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      cycle();
      seen = dwrite;
    end
    check("mid_reached_access", 16'(seen), 16'd1);
    reset = 1'b0;
    #1 check("mid_dwrite_gated", 16'(dwrite), 16'd0);
    cycle();
    check("mid_no_ack", 16'(ack0), 16'd0);
    reset = 1'b1;
    r_req[0] = 1'b0;
    cycle();
    do_txn(0, 1'b0, 16'h0008, 16'h0000, lat, ndw);
    check("mid_prior_value", rdata0, 16'h1111);
    check("mid_count", txn_count, 16'd1);

    // Randomized traffic with occasional resets and switch changes.
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!r_req[p] || e_ack[p]) begin
          r_req[p]   = ($urandom_range(0, 2) != 0);
          r_we[p]    = 1'($urandom_range(0, 1));
          r_addr[p]  = (p == 1 && $urandom_range(0, 7) == 0) ? IoAddr
                                                             : 16'($urandom_range(0, 15));
          r_wdata[p] = 16'($urandom);
        end
      end
      if ($urandom_range(0, 15) == 0) io_sw = 16'($urandom);
      reset = ($urandom_range(0, 299) != 0);
      cycle();
    end

    reset = 1'b1;
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
